dsp_pipe_drain: RTL and testbench
=================================

Name: dsp_pipe_drain

Overview:
- Consumer-side controller for a fixed-latency, CE-gated DSP pipeline built from the team's clock-enabled pipeline registers.
- Owns the pipeline's common clock enable (PIPE_CE) and tracks which stages hold valid operands using a valid shift register.
- Captures each result leaving the last stage into a small FIFO and presents it downstream on a valid/ready interface.
- Stalls (freezes) the whole pipeline instead of dropping data when the downstream side back-pressures.

Parameters:
- WIDTH, 48, bit width of pipeline result PIPE_Q / OUT_DATA.
- LATENCY, 4, number of CE-gated register stages between operand issue and PIPE_Q; legal range 1..16.
- DEPTH, 4, output FIFO entries; must be a power of 2, minimum 2.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- FLUSH  in  1  synchronous clear of all in-flight and buffered results.
- IN_VALID  in  1  operand issued to pipeline stage 0 this cycle.
- IN_READY  out  1  operand accepted when IN_VALID && IN_READY; equals PIPE_CE && !FLUSH.
- PIPE_CE  out  1  clock enable driven to every upstream pipeline register.
- PIPE_Q  in  WIDTH  output of the last pipeline stage.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  downstream accepts OUT_DATA.
- OUT_DATA  out  WIDTH  head of FIFO; 0 when empty.
- LEVEL  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- State:
  - vld_sr[LATENCY-1:0]; tail = vld_sr[LATENCY-1].
  - FIFO: memory, rd/wr pointers with an extra wrap bit, and LEVEL.
- Reset (RST high, async): vld_sr=0, pointers=0, LEVEL=0, OUT_VALID=0, OUT_DATA=0. PIPE_CE=1 and IN_READY=1 once RST is released.
- PIPE_CE = !FLUSH && (!tail || LEVEL != DEPTH).
  - Purely combinational from registered state; no combinational path from OUT_READY or IN_VALID.
- Valid tracking: when PIPE_CE=1, vld_sr <= {vld_sr[LATENCY-2:0], IN_VALID}. For LATENCY=1, vld_sr <= IN_VALID. When PIPE_CE=0, vld_sr holds.
- push = PIPE_CE && tail. On push, PIPE_Q is written at wr pointer.
- pop = OUT_VALID && OUT_READY.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Latency: an operand accepted at edge N appears on OUT_DATA with OUT_VALID=1 after edge N+LATENCY+1, provided no stall occurs in between.
- Full boundary: with LEVEL==DEPTH and tail=1, PIPE_CE=0 and the pipeline freezes. A pop that cycle lowers LEVEL, and PIPE_CE rises the following cycle. This one-cycle bubble is intended.
- Full with tail=0: PIPE_CE stays 1, so bubbles keep flowing and upstream issue continues.
- Empty boundary: OUT_VALID=0 and OUT_DATA=0. OUT_READY is ignored.
- Pointer wrap: modulo DEPTH. full = (ptr LSBs equal) && (wrap bits differ).
- FLUSH (synchronous, wins over push/pop/issue): next edge clears vld_sr, pointers and LEVEL. PIPE_CE=0 and IN_READY=0 while FLUSH is high.
- RST mid-operation: all in-flight and buffered results are discarded immediately. No partial output is produced.
- Ordering: strict in-order; every accepted operand yields exactly one output unless a FLUSH or RST intervenes.

Optional Feature:
- Macro: DSP_DRAIN_STATS_EN.
- When defined:
  - Adds output STALL_CNT (16 bits), a saturating count of cycles with PIPE_CE=0 && !FLUSH.
  - Adds output OVF_SEEN (1 bit), sticky, set when pop is attempted while empty (protocol-violation monitor).
  - Both are cleared by RST or FLUSH.
- When undefined: neither port nor its logic exists. Core behaviour is identical.

Test Plan:
- Streaming: WIDTH=48, LATENCY=4, DEPTH=4; OUT_READY=1; issue 10 back-to-back operands with PIPE_Q driven per stage model -> first OUT_VALID 5 cycles after first accept; 10 outputs in order; PIPE_CE never 0; LEVEL ≤1.
- Back-pressure: OUT_READY=0 for 20 cycles while issuing continuously -> LEVEL reaches 4; PIPE_CE=0 with tail=1; no result lost or duplicated after OUT_READY=1; STALL_CNT matches stall cycle count (macro on).
- Bubbles while full: LEVEL=4, issue with gaps of 3 idle cycles -> PIPE_CE stays 1 until a valid result reaches tail, then drops.
- Simultaneous push/pop at LEVEL=2 -> LEVEL stays 2; pointer wrap exercised over 12 results with data matching 0x1..0xC.
- FLUSH with 3 in-flight and 2 buffered -> next cycle LEVEL=0, OUT_VALID=0, vld_sr=0; following issue emerges after 5 cycles.
- Async RST asserted mid-stall between clock edges -> OUT_VALID/OUT_DATA/LEVEL go to 0 immediately; PIPE_CE=1 after release.

Source files
------------

// File: rtl/dsp_pipe_drain_if.sv
// ============================================================================
//  Module      : dsp_pipe_drain_if
//  Description : Issue, pipeline-tap and output-stream signals of the drain
//                controller, with controller (slave) and environment (master)
//                views.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dsp_pipe_drain_if #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
);
    localparam int c_LW = $clog2(DEPTH) + 1;

    logic             IN_VALID;
    logic             IN_READY;
    logic             PIPE_CE;
    logic [WIDTH-1:0] PIPE_Q;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [c_LW-1:0]  LEVEL;

    modport slave (
        input  IN_VALID, PIPE_Q, OUT_READY,
        output IN_READY, PIPE_CE, OUT_VALID, OUT_DATA, LEVEL
    );

    modport master (
        output IN_VALID, PIPE_Q, OUT_READY,
        input  IN_READY, PIPE_CE, OUT_VALID, OUT_DATA, LEVEL
    );
endinterface

`default_nettype wire

// File: rtl/dsp_pipe_drain.sv
// ============================================================================
//  Module      : dsp_pipe_drain
//  Description : Clock-enable owner and result drain FIFO for a fixed-latency
//                CE-gated DSP pipeline; freezes the pipe instead of dropping.
//                Optional stall/overflow stats: define DSP_DRAIN_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dsp_pipe_drain #(
    parameter int WIDTH   = 48,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    input  wire logic        FLUSH,
    dsp_pipe_drain_if.slave  bus
`ifdef DSP_DRAIN_STATS_EN
    ,
    output logic [15:0]      STALL_CNT,
    output logic             OVF_SEEN
`endif
);

    localparam int               c_AW  = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_ONE = (c_AW+1)'(1);

    logic [LATENCY-1:0] r_vld_sr;
    logic [LATENCY-1:0] w_vld_next;
    logic [c_AW:0]      r_wr;
    logic [c_AW:0]      r_rd;
    logic [c_AW:0]      r_level;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic w_tail;
    logic w_full;
    logic w_ce;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_tail      = r_vld_sr[LATENCY-1];
    assign w_full      = (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]) && (r_wr[c_AW] != r_rd[c_AW]);
    // Only a valid result at the tail needs a FIFO slot; bubbles may always advance.
    assign w_ce        = !FLUSH && (!w_tail || !w_full);
    assign w_out_valid = (r_level != '0);
    assign w_push      = w_ce && w_tail;
    assign w_pop       = w_out_valid && bus.OUT_READY;

    generate
        if (LATENCY == 1) begin : g_sr1
            assign w_vld_next = bus.IN_VALID;
        end else begin : g_srn
            assign w_vld_next = {r_vld_sr[LATENCY-2:0], bus.IN_VALID};
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld_sr <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_level  <= '0;
        end else if (FLUSH) begin
            r_vld_sr <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_level  <= '0;
        end else begin
            if (w_ce) begin
                r_vld_sr <= w_vld_next;
            end
            if (w_push) begin
                r_wr <= r_wr + c_ONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + c_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_ONE;
            end
        end
    end

    // Storage needs no reset: reads are masked by the occupancy count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr[c_AW-1:0]] <= bus.PIPE_Q;
        end
    end

    assign bus.PIPE_CE   = w_ce;
    assign bus.IN_READY  = w_ce;
    assign bus.OUT_VALID = w_out_valid;
    assign bus.OUT_DATA  = w_out_valid ? r_mem[r_rd[c_AW-1:0]] : '0;
    assign bus.LEVEL     = r_level;

`ifdef DSP_DRAIN_STATS_EN
    logic [15:0] r_stall_cnt;
    logic        r_ovf_seen;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_ovf_seen  <= 1'b0;
        end else if (FLUSH) begin
            r_stall_cnt <= '0;
            r_ovf_seen  <= 1'b0;
        end else begin
            if (!w_ce && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (bus.OUT_READY && !w_out_valid) begin
                r_ovf_seen <= 1'b1;
            end
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign OVF_SEEN  = r_ovf_seen;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dsp_pipe_drain.sv
// ============================================================================
//  Module      : tb_dsp_pipe_drain
//  Description : Directed self-checking bench for dsp_pipe_drain with a
//                CE-gated upstream pipeline model (WIDTH=48, LATENCY=4, DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dsp_pipe_drain;

    localparam int W = 48;
    localparam int L = 4;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         FLUSH;
    logic [W-1:0] in_data;
    logic [W-1:0] stg [L];
    int           checks   = 0;
    int           failures = 0;

    always #5 CLK = ~CLK;

    dsp_pipe_drain_if #(.WIDTH(W), .DEPTH(D)) bus ();

`ifdef DSP_DRAIN_STATS_EN
    logic [15:0] stall_cnt;
    logic        ovf_seen;
`endif

    dsp_pipe_drain #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .bus       (bus)
`ifdef DSP_DRAIN_STATS_EN
        ,
        .STALL_CNT (stall_cnt),
        .OVF_SEEN  (ovf_seen)
`endif
    );

    // Upstream pipeline: every stage register is gated by PIPE_CE.
    always @(posedge CLK) begin
        if (bus.PIPE_CE) begin
            stg[0] <= in_data;
            for (int i = 1; i < L; i++) stg[i] <= stg[i-1];
        end
    end
    assign bus.PIPE_Q = stg[L-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        bus.IN_VALID = v;
        in_data      = d;
    endtask

    task automatic drain(input logic [W-1:0] base, input int n, input string tag);
        int got;
        got = 0;
        drive(1'b0, '0);
        bus.OUT_READY = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.OUT_VALID) begin
                chk({tag, "_data"}, bus.OUT_DATA, base + W'(got));
                got++;
            end
            tick();
            if (got == n) break;
        end
        chk({tag, "_count"}, got, n);
        chk({tag, "_empty"}, bus.LEVEL, 0);
    endtask

    initial begin
        RST           = 1'b1;
        FLUSH         = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        in_data       = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ovalid", bus.OUT_VALID, 0);
        chk("rst_odata",  bus.OUT_DATA,  0);
        chk("rst_level",  bus.LEVEL,     0);
        RST = 1'b0;
        #1;
        chk("rel_ce",    bus.PIPE_CE,  1);
        chk("rel_ready", bus.IN_READY, 1);
        tick();

        // Streaming: 10 back-to-back operands, first result 5 cycles after issue
        bus.OUT_READY = 1'b1;
        for (int j = 0; j < 17; j++) begin
            drive(j < 10, W'('h100 + j));
            #1;
            chk("s_ce",    bus.PIPE_CE,   1);
            chk("s_valid", bus.OUT_VALID, (j >= 5 && j < 15));
            chk("s_data",  bus.OUT_DATA,  (j >= 5 && j < 15) ? 64'('h100 + j - 5) : 64'd0);
            chk("s_level", bus.LEVEL,     (j >= 5 && j < 15) ? 64'd1 : 64'd0);
            tick();
        end
`ifdef DSP_DRAIN_STATS_EN
        chk("s_ovf", ovf_seen, 1);
`endif

        // Back-pressure: 8 accepted, FIFO fills at cycle 8, stalls through 19
        bus.OUT_READY = 1'b0;
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, W'('h200 + j));
            #1;
            if (j == 7) begin
                chk("bp_ce7",  bus.PIPE_CE, 1);
                chk("bp_lvl7", bus.LEVEL,   3);
            end
            if (j == 8 || j == 19) begin
                chk("bp_ce",    bus.PIPE_CE,  0);
                chk("bp_ready", bus.IN_READY, 0);
                chk("bp_level", bus.LEVEL,    4);
            end
            tick();
        end
`ifdef DSP_DRAIN_STATS_EN
        chk("bp_stall", stall_cnt, 12);
`endif
        drain(W'('h200), 8, "bp_drain");

        // Bubbles while full: CE stays high until the valid result reaches the tail
        bus.OUT_READY = 1'b0;
        for (int j = 0; j < 14; j++) begin
            drive(j < 4 || j == 9, (j == 9) ? W'('h304) : W'('h300 + j));
            #1;
            if (j == 8)           chk("bub_level", bus.LEVEL, 4);
            if (j >= 8 && j < 13) chk("bub_ce", bus.PIPE_CE, 1);
            if (j == 13) begin
                chk("bub_stall", bus.PIPE_CE, 0);
                chk("bub_lvl13", bus.LEVEL,   4);
            end
            tick();
        end
        drain(W'('h300), 5, "bub_drain");

        // Simultaneous push/pop at LEVEL=2 with pointer wrap over 0x1..0xC
        for (int j = 0; j < 19; j++) begin
            drive(j < 12, W'(j + 1));
            bus.OUT_READY = (j >= 6);
            #1;
            if (j >= 6 && j <= 16) begin
                chk("pp_level", bus.LEVEL,    2);
                chk("pp_data",  bus.OUT_DATA, j - 5);
            end
            if (j == 17) begin
                chk("pp_lvl17", bus.LEVEL,    1);
                chk("pp_d17",   bus.OUT_DATA, 'hC);
            end
            if (j == 18) chk("pp_end", bus.OUT_VALID, 0);
            tick();
        end

        // FLUSH with 3 in flight and 2 buffered
        bus.OUT_READY = 1'b0;
        for (int j = 0; j < 7; j++) begin
            drive(j < 5, W'('h500 + j));
            FLUSH = (j == 6);
            #1;
            if (j == 6) begin
                chk("fl_level", bus.LEVEL,    2);
                chk("fl_ready", bus.IN_READY, 0);
                chk("fl_ce",    bus.PIPE_CE,  0);
            end
            tick();
        end
        FLUSH = 1'b0;
        drive(1'b1, W'('h5AA));
        #1;
        chk("fl_lvl0",   bus.LEVEL,     0);
        chk("fl_ovalid", bus.OUT_VALID, 0);
        chk("fl_odata",  bus.OUT_DATA,  0);
        chk("fl_ce_up",  bus.PIPE_CE,   1);
`ifdef DSP_DRAIN_STATS_EN
        chk("fl_stall", stall_cnt, 0);
        chk("fl_ovf",   ovf_seen,  0);
`endif
        tick();
        for (int j = 8; j < 13; j++) begin
            drive(1'b0, '0);
            #1;
            chk("fl_after", bus.OUT_VALID, (j == 12));
            if (j == 12) chk("fl_data", bus.OUT_DATA, 'h5AA);
            tick();
        end
        drain(W'('h5AA), 1, "fl_drain");

        // Async RST asserted mid-stall, between clock edges
        bus.OUT_READY = 1'b0;
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, W'('h600 + j));
            tick();
        end
        #1;
        chk("ar_level", bus.LEVEL,   4);
        chk("ar_ce",    bus.PIPE_CE, 0);
        #1;
        RST = 1'b1;
        #1;
        chk("ar_ovalid", bus.OUT_VALID, 0);
        chk("ar_odata",  bus.OUT_DATA,  0);
        chk("ar_lvl0",   bus.LEVEL,     0);
`ifdef DSP_DRAIN_STATS_EN
        chk("ar_stall", stall_cnt, 0);
`endif
        #1;
        RST = 1'b0;
        drive(1'b0, '0);
        tick();
        chk("ar_ce_up", bus.PIPE_CE,  1);
        chk("ar_ready", bus.IN_READY, 1);
        for (int j = 0; j < 7; j++) begin
            chk("ar_quiet", bus.OUT_VALID, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
